// File: rtl/axi4_pkg.sv
// Shared AXI4 types and constants for the burst master and its checkers.
package axi4_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE
    } state_t;

    localparam int unsigned BOUNDARY_4K = 4096;

    // AxSIZE encoding: log2 of the bus width in bytes.
    function automatic logic [2:0] axsize(input int unsigned data_width);
        logic [2:0] s;
        s = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((32'd1 << i) == data_width / 8) s = 3'(i);
        end
        return s;
    endfunction

endpackage

// File: rtl/axi4_boundary_check.sv
// Combinational legality check for an INCR burst: start address aligned to
// the bus width and the whole burst contained within one 4 KB page.
module axi4_boundary_check
    import axi4_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [11:0] addr_i,   // only the page offset matters
    input  logic [7:0]  len_i,
    output logic        ok_o
);
    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam logic [2:0]  SZ    = axsize(DATA_WIDTH);

    logic [31:0] end_off;
    logic        aligned;

    // Offset of the byte just past the burst, relative to the page base.
    always_comb begin
        end_off = 32'(addr_i) + ((32'(len_i) + 32'd1) << SZ);
        aligned = (32'(addr_i) & (BYTES - 1)) == 32'd0;
        ok_o    = aligned && (end_off <= BOUNDARY_4K);
    end

endmodule

// File: rtl/axi4_burst_master.sv
// Single-command AXI4 INCR burst master: one read or write burst at a time,
// with local valid/ready streams for write and read data.
// Optional build macro AXI4_MASTER_TIMEOUT_EN adds a stall watchdog and the
// err_timeout output.
module axi4_burst_master
    import axi4_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_BEATS      = 256,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [7:0]              cmd_len,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_last,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic                    done,
    output logic [1:0]              done_resp,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic [3:0]              m_axi_awcache,
    output logic [2:0]              m_axi_awprot,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
`ifdef AXI4_MASTER_TIMEOUT_EN
    ,output logic                   err_timeout
`endif
);
    // One extra bit so that a 256-beat burst counts to 256 without wrapping.
    localparam int BEAT_W = $clog2(MAX_BEATS) + 1;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [1:0]            resp_q, resp_d;
    logic                  rlast_err_q, rlast_err_d;
    logic                  cmd_ok;
    logic                  last_beat;
    logic                  tmo_cmd;

    axi4_boundary_check #(.DATA_WIDTH(DATA_WIDTH)) u_chk (
        .addr_i (cmd_addr[11:0]),
        .len_i  (cmd_len),
        .ok_o   (cmd_ok)
    );

    assign m_axi_awaddr  = addr_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_awlen   = len_q;
    assign m_axi_arlen   = len_q;
    assign m_axi_awsize  = axsize(DATA_WIDTH);
    assign m_axi_arsize  = axsize(DATA_WIDTH);
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_arburst = BURST_INCR;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_wdata   = wr_data;
    assign m_axi_wstrb   = wr_strb;
    assign rd_data       = m_axi_rdata;
    assign last_beat     = (beat_q == BEAT_W'(len_q));

    // State and per-command context registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            resp_q      <= RESP_OKAY;
            rlast_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            resp_q      <= resp_d;
            rlast_err_q <= rlast_err_d;
        end
    end

    // Next-state and handshake outputs; valids only rise on state entry.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        len_d         = len_q;
        beat_d        = beat_q;
        resp_d        = resp_q;
        rlast_err_d   = rlast_err_q;
        cmd_ready     = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_wlast   = 1'b0;
        wr_ready      = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        rd_valid      = 1'b0;
        rd_last       = 1'b0;
        done          = 1'b0;
        done_resp     = RESP_OKAY;
        unique case (state_q)
            S_IDLE: begin
                // Held low while in reset so no command looks accepted.
                cmd_ready = rst_n;
                if (cmd_valid) begin
                    addr_d      = cmd_addr;
                    len_d       = cmd_len;
                    beat_d      = '0;
                    rlast_err_d = 1'b0;
                    if (!cmd_ok) begin
                        resp_d  = RESP_SLVERR;
                        state_d = S_DONE;
                    end else begin
                        resp_d  = RESP_OKAY;
                        state_d = cmd_write ? S_AW : S_AR;
                    end
                end
            end
            S_AR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) state_d = S_R;
            end
            S_R: begin
                m_axi_rready = rd_ready;
                rd_valid     = m_axi_rvalid;
                rd_last      = last_beat;
                if (m_axi_rvalid && rd_ready) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (m_axi_rresp > resp_q) resp_d = m_axi_rresp;
                    if (m_axi_rlast != last_beat) rlast_err_d = 1'b1;
                    if (last_beat) state_d = S_DONE;
                end
            end
            S_AW: begin
                m_axi_awvalid = 1'b1;
                if (m_axi_awready) state_d = S_W;
            end
            S_W: begin
                m_axi_wvalid = wr_valid;
                wr_ready     = m_axi_wready;
                m_axi_wlast  = last_beat;
                if (wr_valid && m_axi_wready) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (last_beat) state_d = S_B;
                end
            end
            S_B: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    resp_d  = m_axi_bresp;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                done_resp = tmo_cmd     ? RESP_DECERR :
                            rlast_err_q ? RESP_SLVERR : resp_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef AXI4_MASTER_TIMEOUT_EN
    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        err_q, tmo_cmd_q, any_hs;

    assign any_hs = (m_axi_awvalid && m_axi_awready) || (m_axi_wvalid && m_axi_wready) ||
                    (m_axi_arvalid && m_axi_arready) || (m_axi_rvalid && m_axi_rready) ||
                    (m_axi_bvalid && m_axi_bready);

    // Stall counter: any progress or idling restarts it; saturates at the limit.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == S_IDLE || any_hs) tmo_cnt_d = '0;
        else if (tmo_cnt_q != TMO_LIMIT) tmo_cnt_d = tmo_cnt_q + 16'd1;
    end

    // Sticky error plus a per-command flag that overrides the final response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
            tmo_cmd_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            if (tmo_cnt_d == TMO_LIMIT) begin
                err_q     <= 1'b1;
                tmo_cmd_q <= 1'b1;
            end else if (state_q == S_IDLE) begin
                tmo_cmd_q <= 1'b0;
            end
        end
    end

    assign err_timeout = err_q;
    assign tmo_cmd     = tmo_cmd_q;
`else
    assign tmo_cmd = 1'b0;
`endif

endmodule

// File: tb/tb_axi4_burst_master.sv
// Randomized bench for axi4_burst_master: reactive AXI slave with a 4 KB
// memory, a bench-side memory model predicting read data and responses, and
// one per-cycle compare process.
module tb_axi4_burst_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        wr_valid, wr_ready;
    logic [31:0] rd_data;
    logic        rd_last, rd_valid, rd_ready;
    logic        done;
    logic [1:0]  done_resp;
    logic [31:0] m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_rdata;
    logic [7:0]  m_axi_awlen, m_axi_arlen;
    logic [2:0]  m_axi_awsize, m_axi_arsize, m_axi_awprot;
    logic [1:0]  m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
    logic [3:0]  m_axi_awcache, m_axi_wstrb;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
`ifdef AXI4_MASTER_TIMEOUT_EN
    logic        err_timeout;
`endif

    axi4_burst_master dut (
`ifdef AXI4_MASTER_TIMEOUT_EN
        .err_timeout(err_timeout),
`endif
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .done(done), .done_resp(done_resp),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Memories: what the slave actually holds, and what the bench predicts.
    logic [31:0] slv_mem   [0:1023];
    logic [31:0] model_mem [0:1023];

    // Expectations for the command in flight.
    logic [31:0] exp_data[$];
    logic [3:0]  exp_strb[$];
    logic [31:0] exp_addr;
    int          exp_len;
    bit          exp_write, exp_bad;
    logic [1:0]  exp_resp;
    int          last_beats;
    logic [1:0]  last_resp;
    int          inj_beat = -1;
    bit          hold_aw  = 1'b0;
    bit          tmo_mode = 1'b0;

    // ---------------- AXI slave: drive at negedge, observe at negedge+3 ----
    initial begin : slave
        int aw_wait, ar_wait, b_wait, wa_len, wcnt, ra_len, rcnt;
        logic [31:0] wa_addr, ra_addr;
        bit b_pend, r_act, r_pend;
        aw_wait = $urandom_range(2, 10); ar_wait = $urandom_range(2, 10);
        b_wait = 0; b_pend = 0; r_act = 0; r_pend = 0;
        wa_addr = 0; wa_len = 0; wcnt = 0; ra_addr = 0; ra_len = 0; rcnt = 0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0; m_axi_rlast = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                b_pend = 0; r_act = 0; r_pend = 0;
                m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
                m_axi_arready = 0; m_axi_rvalid = 0;
                continue;
            end
            m_axi_awready = !hold_aw && aw_wait == 0;
            m_axi_arready = ar_wait == 0;
            m_axi_wready  = $urandom_range(0, 3) != 0;
            m_axi_bvalid  = b_pend && b_wait == 0;
            m_axi_bresp   = 2'b00;
            if (!r_act) r_pend = 0;
            else if (!r_pend) r_pend = $urandom_range(0, 3) != 0;
            m_axi_rvalid = r_pend;
            m_axi_rdata  = r_act ? slv_mem[(ra_addr >> 2) + rcnt] : 32'h0;
            m_axi_rresp  = (r_act && rcnt == inj_beat) ? 2'b10 : 2'b00;
            m_axi_rlast  = r_act && rcnt == ra_len;
            #3;
            if (m_axi_awvalid && m_axi_awready) begin
                wa_addr = m_axi_awaddr; wa_len = m_axi_awlen; wcnt = 0;
                aw_wait = $urandom_range(2, 10);
            end else if (m_axi_awvalid && aw_wait > 0) aw_wait--;
            if (m_axi_bvalid && m_axi_bready) b_pend = 0;
            else if (b_pend && b_wait > 0) b_wait--;
            if (m_axi_wvalid && m_axi_wready) begin
                for (int b = 0; b < 4; b++)
                    if (m_axi_wstrb[b]) slv_mem[(wa_addr >> 2) + wcnt][8*b +: 8] = m_axi_wdata[8*b +: 8];
                wcnt++;
                if (wcnt == wa_len + 1) begin b_pend = 1; b_wait = $urandom_range(0, 4); end
            end
            if (m_axi_arvalid && m_axi_arready) begin
                ra_addr = m_axi_araddr; ra_len = m_axi_arlen; rcnt = 0; r_act = 1;
                ar_wait = $urandom_range(2, 10);
            end else if (m_axi_arvalid && ar_wait > 0) ar_wait--;
            if (m_axi_rvalid && m_axi_rready) begin
                r_pend = 0; rcnt++;
                if (rcnt > ra_len) r_act = 0;
            end
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    initial begin : compare
        int ci;
        bit aw_done;
        ci = 0; aw_done = 0;
        forever begin
            @(negedge clk); #4;
            if (!rst_n) begin ci = 0; aw_done = 0; continue; end
            chk(m_axi_awsize == 3'd2 && m_axi_arsize == 3'd2, "axsize", {m_axi_awsize, m_axi_arsize}, 6'o22);
            chk(m_axi_awburst == 2'b01 && m_axi_arburst == 2'b01 && m_axi_awcache == 4'b0011 &&
                m_axi_awprot == 3'b000, "const_attr", {m_axi_awburst, m_axi_arburst, m_axi_awcache, m_axi_awprot},
                {2'b01, 2'b01, 4'b0011, 3'b000});
            if (exp_bad)
                chk(!m_axi_awvalid && !m_axi_arvalid, "no_traffic_on_bad", {m_axi_awvalid, m_axi_arvalid}, 0);
            if (m_axi_awvalid)
                chk(exp_write && m_axi_awaddr == exp_addr && m_axi_awlen == 8'(exp_len), "aw_req",
                    {m_axi_awaddr, m_axi_awlen}, {exp_addr, 8'(exp_len)});
            if (m_axi_arvalid)
                chk(!exp_write && m_axi_araddr == exp_addr && m_axi_arlen == 8'(exp_len), "ar_req",
                    {m_axi_araddr, m_axi_arlen}, {exp_addr, 8'(exp_len)});
            if (m_axi_awvalid && m_axi_awready) aw_done = 1;
            if (m_axi_wvalid && m_axi_wready) begin
                chk(aw_done, "w_after_aw", 0, 1);
                if (ci < exp_data.size())
                    chk(m_axi_wdata == exp_data[ci] && m_axi_wstrb == exp_strb[ci] && m_axi_wlast == (ci == exp_len),
                        "w_beat", {m_axi_wdata, m_axi_wstrb, m_axi_wlast}, {exp_data[ci], exp_strb[ci], ci == exp_len});
                else chk(0, "w_extra_beat", ci, exp_len);
                ci++;
            end
            chk((m_axi_rvalid && m_axi_rready) == (rd_valid && rd_ready), "r_forward",
                {m_axi_rvalid, m_axi_rready}, {rd_valid, rd_ready});
            if (rd_valid && rd_ready) begin
                if (ci < exp_data.size())
                    chk(rd_data == exp_data[ci] && rd_last == (ci == exp_len), "r_beat",
                        {rd_data, rd_last}, {exp_data[ci], ci == exp_len});
                else chk(0, "r_extra_beat", ci, exp_len);
                ci++;
            end
            if (done) begin
                chk(done_resp == exp_resp, "done_resp", done_resp, exp_resp);
                chk(ci == (exp_bad ? 0 : exp_len + 1), "beat_count", ci, exp_bad ? 0 : exp_len + 1);
                last_beats = ci;
                ci = 0; aw_done = 0;
            end
        end
    end

    // rdmode: 0 always ready, 1 toggle each cycle, 2 random.
    task automatic do_cmd(input bit w, input logic [31:0] addr, input int len, input int rdmode, input bit fixed);
        int base, n, wi, acc_cyc, done_cyc;
        bit isbad, acc, got, wv;
        logic [31:0] d;
        logic [3:0]  s;
        base  = int'(addr / 4);
        isbad = (addr % 4 != 0) || ((addr % 4096) + (len + 1) * 4 > 4096);
        exp_data.delete(); exp_strb.delete();
        for (int i = 0; i <= len; i++) begin
            if (w) begin
                d = fixed ? 32'((i + 1) * 32'h11) : $urandom;
                s = fixed ? 4'hF : 4'($urandom_range(0, 15));
                exp_data.push_back(d); exp_strb.push_back(s);
                if (!isbad)
                    for (int b = 0; b < 4; b++) if (s[b]) model_mem[base + i][8*b +: 8] = d[8*b +: 8];
            end else if (!isbad) exp_data.push_back(model_mem[base + i]);
        end
        exp_write = w; exp_addr = addr; exp_len = len; exp_bad = isbad;
        if (isbad) exp_resp = 2'b10;
        else if (tmo_mode) exp_resp = 2'b11;
        else if (!w && inj_beat >= 0 && inj_beat <= len) exp_resp = 2'b10;
        else exp_resp = 2'b00;

        @(negedge clk);
        cmd_valid = 1; cmd_write = w; cmd_addr = addr; cmd_len = 8'(len);
        acc = 0; n = 0; acc_cyc = 0;
        while (!acc && n < 100) begin
            #3;
            if (cmd_ready) begin acc = 1; acc_cyc = cyc; end
            @(negedge clk); n++;
        end
        cmd_valid = 0;
        if (!acc) chk(0, "cmd_accept_timeout", n, 100);
        wi = 0; got = 0; n = 0; wv = 0; done_cyc = 0;
        while (acc && !got && n < 6000) begin
            if (w && wi <= len) begin
                if (!wv) wv = $urandom_range(0, 3) != 0;
                wr_data = exp_data[wi]; wr_strb = exp_strb[wi];
            end else wv = 0;
            wr_valid = wv;
            rd_ready = rdmode == 0 ? 1'b1 : rdmode == 1 ? ~rd_ready : 1'($urandom_range(0, 1));
            #3;
            if (wr_valid && wr_ready) begin wi++; wv = 0; end
            if (done) begin got = 1; done_cyc = cyc; last_resp = done_resp; end
            @(negedge clk); n++;
        end
        wr_valid = 0; rd_ready = 0;
        if (acc && !got) chk(0, "done_timeout", n, 6000);
        if (got && isbad) chk(done_cyc - acc_cyc == 1, "bad_done_latency", done_cyc - acc_cyc, 1);
    endtask

    initial begin : main
        int mism;
        for (int i = 0; i < 1024; i++) begin slv_mem[i] = 0; model_mem[i] = 0; end
        exp_bad = 0; exp_write = 0; exp_addr = 0; exp_len = 0; exp_resp = 0;
        last_beats = 0; last_resp = 0;
        rst_n = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
        wr_data = 0; wr_strb = 0; wr_valid = 0; rd_ready = 0;
        repeat (3) @(negedge clk);
        #3;
        chk({cmd_ready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready,
             rd_valid, wr_ready, done} == 0, "reset_handshakes",
            {cmd_ready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready,
             rd_valid, wr_ready, done}, 0);
        chk(done_resp == 0, "reset_done_resp", done_resp, 0);
        chk({m_axi_awaddr, m_axi_awlen, m_axi_araddr, m_axi_arlen} == 0, "reset_addr_len",
            {m_axi_awaddr, m_axi_awlen}, 0);
        @(negedge clk); rst_n = 1;

        // Fixed write 0x11..0x44, then read it back with a toggling rd_ready.
        do_cmd(1, 32'h100, 3, 0, 1);
        chk(last_resp == 2'b00, "wr_resp_lit", last_resp, 2'b00);
        for (int i = 0; i < 4; i++) begin
            mism = (i + 1) * 17;
            chk(slv_mem[64 + i] == 32'(mism), "wr_mem_lit", slv_mem[64 + i], mism);
        end
        chk(model_mem[67] == 32'h44, "model_mem_lit", model_mem[67], 32'h44);
        do_cmd(0, 32'h100, 3, 1, 0);
        chk(last_resp == 2'b00 && last_beats == 4, "rd_lit", {last_resp, 8'(last_beats)}, {2'b00, 8'd4});

        // Illegal commands: page crossing and misalignment.
        do_cmd(1, 32'hFF8, 3, 0, 0);
        chk(last_resp == 2'b10, "cross_wr_lit", last_resp, 2'b10);
        do_cmd(0, 32'hFF8, 3, 0, 0);
        do_cmd(0, 32'h102, 0, 0, 0);
        chk(last_resp == 2'b10, "misalign_lit", last_resp, 2'b10);
        // Burst ending exactly at the page boundary is legal.
        do_cmd(1, 32'hFF0, 3, 2, 0);
        chk(last_resp == 2'b00, "edge_4k_lit", last_resp, 2'b00);

        // Maximum-length bursts.
        do_cmd(1, 32'h400, 255, 0, 0);
        do_cmd(0, 32'h400, 255, 2, 0);
        chk(last_beats == 256, "len255_beats_lit", last_beats, 256);

        // Slave error on beat 2 of 4: all beats still forwarded.
        inj_beat = 1;
        do_cmd(0, 32'h100, 3, 0, 0);
        inj_beat = -1;
        chk(last_resp == 2'b10 && last_beats == 4, "rresp_err_lit", {last_resp, 8'(last_beats)}, {2'b10, 8'd4});

        // Random traffic.
        repeat (30) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 1023) * 4);
            if ($urandom_range(0, 7) == 0) a = a + 2;
            inj_beat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
            do_cmd(1'($urandom_range(0, 1)), a, int'($urandom_range(0, 15)), int'($urandom_range(0, 2)), 0);
        end
        inj_beat = -1;

`ifdef AXI4_MASTER_TIMEOUT_EN
        hold_aw = 1; tmo_mode = 1;
        fork
            begin
                repeat (1100) @(negedge clk);
                #4;
                chk(m_axi_awvalid, "tmo_awvalid_held", m_axi_awvalid, 1);
                chk(err_timeout, "tmo_err_set", err_timeout, 1);
                @(negedge clk); hold_aw = 0;
            end
        join_none
        do_cmd(1, 32'h200, 0, 0, 0);
        tmo_mode = 0;
        chk(last_resp == 2'b11, "tmo_resp_lit", last_resp, 2'b11);
`endif

        mism = 0;
        for (int i = 0; i < 1024; i++) if (slv_mem[i] != model_mem[i]) mism++;
        chk(mism == 0, "memory_image", mism, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL global_timeout got=%0d want=finish", cyc);
        $fatal(1, "bench did not finish");
    end

endmodule
